// File: rtl/switch_hit_detector.sv
// Debounced switch bank. Qualified level changes are queued as sticky pending bits and
// presented one at a time, lowest channel first, through a valid/ready handshake.
module switch_hit_detector #(
    parameter int N_CH            = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDX_W           = $clog2(N_CH)
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic [N_CH-1:0]  switches,
    input  logic [1:0]       mode,
    input  logic             hit_ready,
    output logic [N_CH-1:0]  level,
    output logic [N_CH-1:0]  hit_pulse,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_index,
    output logic             hit_overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [N_CH-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [1:0]       init_q;
    logic [N_CH-1:0]  evt_q, evt_d;
    logic [N_CH-1:0]  pulse_q;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  clr;
    logic             state_q, state_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] low_idx;
    logic             overrun_q, overrun_d;
    logic             qual_rise, qual_fall;

    assign qual_rise = (mode == 2'b00) || (mode == 2'b01);
    assign qual_fall = (mode == 2'b00) || (mode == 2'b10);

    // Counter holds DEBOUNCE_CYCLES for one cycle before the stable level is committed.
    always_comb begin
        stable_d = stable_q;
        evt_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (init_q != 2'd0) begin
            stable_d = sync2_q;
            for (int i = 0; i < N_CH; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                    evt_d[i]    = sync2_q[i] ? qual_rise : qual_fall;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        clr       = '0;
        state_d   = state_q;
        valid_d   = valid_q;
        index_d   = index_q;
        if (state_q == ST_PRESENT && hit_ready) begin
            clr[index_q] = 1'b1;
        end
        // A new event landing on the channel being acknowledged re-arms it silently.
        pending_d = (pending_q & ~clr) | evt_q;
        overrun_d = |(evt_q & pending_q & ~clr);
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    index_d = low_idx;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            default: begin
                if (hit_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            init_q    <= 2'd3;
            evt_q     <= '0;
            pulse_q   <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            index_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= switches;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (init_q != 2'd0) init_q <= init_q - 2'd1;
            evt_q     <= evt_d;
            pulse_q   <= evt_q;
            pending_q <= pending_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            overrun_q <= overrun_d;
        end
    end

    assign level       = stable_q;
    assign hit_pulse   = pulse_q;
    assign hit_valid   = valid_q;
    assign hit_index   = index_q;
    assign hit_overrun = overrun_q;

endmodule

// File: tb/tb_switch_hit_detector.sv
// Directed bench for switch_hit_detector with N_CH=8, DEBOUNCE_CYCLES=4.
module tb_switch_hit_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] switches;
    logic [1:0] mode;
    logic       hit_ready;
    logic [7:0] level;
    logic [7:0] hit_pulse;
    logic       hit_valid;
    logic [2:0] hit_index;
    logic       hit_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    switch_hit_detector #(
        .N_CH(8),
        .DEBOUNCE_CYCLES(4),
        .IDX_W(3)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .switches   (switches),
        .mode       (mode),
        .hit_ready  (hit_ready),
        .level      (level),
        .hit_pulse  (hit_pulse),
        .hit_valid  (hit_valid),
        .hit_index  (hit_index),
        .hit_overrun(hit_overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (hit_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (level !== 8'h00) begin n_fail++; $display("FAIL reset_level got %h want 00", level); end
        n_checks++;
        if (hit_pulse !== 8'h00) begin n_fail++; $display("FAIL reset_pulse got %h want 00", hit_pulse); end
        n_checks++;
        if ({hit_valid, hit_index, hit_overrun} !== 5'b0) begin
            n_fail++; $display("FAIL reset_hit got v=%b i=%0d o=%b want 0", hit_valid, hit_index, hit_overrun);
        end
    endtask

    task automatic test_basic();
        switches[3] = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step();
            n_checks++;
            if (level[3] !== (i >= 6)) begin
                n_fail++; $display("FAIL basic_level step %0d got %b want %b", i, level[3], (i >= 6));
            end
            n_checks++;
            if (hit_pulse !== ((i == 7) ? 8'h08 : 8'h00)) begin
                n_fail++; $display("FAIL basic_pulse step %0d got %h", i, hit_pulse);
            end
            n_checks++;
            if (hit_valid !== (i == 8)) begin
                n_fail++; $display("FAIL basic_valid step %0d got %b want %b", i, hit_valid, (i == 8));
            end
        end
        n_checks++;
        if (hit_index !== 3'd3) begin n_fail++; $display("FAIL basic_index got %0d want 3", hit_index); end
        hit_ready = 1'b1;
        step();
        hit_ready = 1'b0;
        n_checks++;
        if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_clear got %b want 0", hit_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_stay_clear got %b want 0", hit_valid); end
        end
    endtask

    task automatic test_glitch();
        switches[5] = 1'b1;
        step(); step(); step();
        switches[5] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (level !== 8'h08 || hit_pulse !== 8'h00 || hit_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch step %0d got level=%h pulse=%h valid=%b want 08/00/0",
                         i, level, hit_pulse, hit_valid);
            end
        end
    endtask

    task automatic test_mode();
        int n;
        mode = 2'b11;
        switches[2] = 1'b1;
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (level !== 8'h0C || hit_valid !== 1'b0) begin
            n_fail++; $display("FAIL mode_disabled got level=%h valid=%b want 0c/0", level, hit_valid);
        end
        mode = 2'b01;
        switches[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (hit_pulse !== 8'h00 || hit_valid !== 1'b0) begin
                n_fail++; $display("FAIL mode_fall_ignored got pulse=%h valid=%b want 00/0", hit_pulse, hit_valid);
            end
        end
        n_checks++;
        if (level !== 8'h08) begin n_fail++; $display("FAIL mode_fall_level got %h want 08", level); end
        switches[2] = 1'b1;
        wait_valid(n);
        n_checks++;
        if (n !== 9) begin n_fail++; $display("FAIL mode_rise_latency got %0d want 9", n); end
        n_checks++;
        if (hit_index !== 3'd2) begin n_fail++; $display("FAIL mode_rise_index got %0d want 2", hit_index); end
        hit_ready = 1'b1;
        step();
        hit_ready = 1'b0;
        mode = 2'b00;
    endtask

    task automatic test_back_to_back();
        hit_ready = 1'b1;
        switches = 8'h4E;
        for (int i = 0; i <= 12; i++) begin
            step();
            n_checks++;
            if (hit_pulse !== ((i == 7) ? 8'h42 : 8'h00)) begin
                n_fail++; $display("FAIL b2b_pulse step %0d got %h", i, hit_pulse);
            end
            n_checks++;
            if (hit_valid !== (i == 8 || i == 10)) begin
                n_fail++; $display("FAIL b2b_valid step %0d got %b", i, hit_valid);
            end
            if (i == 8 || i == 10) begin
                n_checks++;
                if (hit_index !== ((i == 8) ? 3'd1 : 3'd6)) begin
                    n_fail++; $display("FAIL b2b_index step %0d got %0d", i, hit_index);
                end
            end
        end
        hit_ready = 1'b0;
    endtask

    task automatic test_overrun();
        switches[4] = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            step();
            n_checks++;
            if (hit_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first step %0d got 1 want 0", i); end
        end
        switches[4] = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            step();
            n_checks++;
            if (hit_overrun !== (j == 7)) begin
                n_fail++; $display("FAIL ovr_second step %0d got %b want %b", j, hit_overrun, (j == 7));
            end
            n_checks++;
            if (hit_valid !== 1'b1 || hit_index !== 3'd4) begin
                n_fail++; $display("FAIL ovr_hold step %0d got v=%b i=%0d want 1/4", j, hit_valid, hit_index);
            end
        end
        hit_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_single_report step %0d got 1 want 0", k); end
        end
        hit_ready = 1'b0;
    endtask

    task automatic test_reset_levels();
        int n;
        reset = 1'b1;
        switches = 8'hFF;
        step(); step(); step();
        n_checks++;
        if (level !== 8'h00) begin n_fail++; $display("FAIL rst_hold_level got %h want 00", level); end
        reset = 1'b0;
        step(); step();
        n_checks++;
        if (level !== 8'h00) begin n_fail++; $display("FAIL rst_copy_early got %h want 00", level); end
        step();
        n_checks++;
        if (level !== 8'hFF) begin n_fail++; $display("FAIL rst_copy_level got %h want ff", level); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (hit_valid !== 1'b0 || hit_pulse !== 8'h00) begin
                n_fail++; $display("FAIL rst_no_hit step %0d got v=%b p=%h", i, hit_valid, hit_pulse);
            end
        end
        switches = 8'hFE;
        wait_valid(n);
        n_checks++;
        if (hit_valid !== 1'b1 || hit_index !== 3'd0) begin
            n_fail++; $display("FAIL rst_present got v=%b i=%0d want 1/0", hit_valid, hit_index);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (hit_valid !== 1'b0 || level !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_op got v=%b level=%h want 0/00", hit_valid, level);
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (hit_valid !== 1'b0 || level !== 8'hFE) begin
            n_fail++; $display("FAIL rst_after got v=%b level=%h want 0/fe", hit_valid, level);
        end
    endtask

    initial begin
        reset     = 1'b1;
        switches  = 8'h00;
        mode      = 2'b00;
        hit_ready = 1'b0;
        step(); step(); step();
        test_reset();
        reset = 1'b0;
        step(); step(); step(); step();
        test_basic();
        test_glitch();
        test_mode();
        test_back_to_back();
        test_overrun();
        test_reset_levels();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
